// File: rtl/haz_scoreboard.sv
// -----------------------------------------------------------------------------
// haz_scoreboard
//   Decode-stage hazard unit built around a shift-register scoreboard of the
//   destination registers still in flight for DEPTH stages after decode (D).
//   Each entry carries a countdown of the cycles left until its result can be
//   forwarded. ALU results and load data have different latencies.
//   From the scoreboard and the D-stage inputs it produces:
//     - a decode bubble request (o_nop),
//     - per-source forward selects (o_fwd_a / o_fwd_b),
//     - a saturating count of stall cycles (o_stall_cnt).
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_freeze            whole pipeline held; the scoreboard and counter hold
//   i_flush             D instruction killed; a bubble is pushed in its place
//   i_valid_D           D holds a real instruction
//   i_is_cmp_D          D resolves a compare in D (needs its operands early)
//   i_is_load_D         D is a load (uses the longer result latency)
//   i_is_write_D        D writes i_reg_c_select_D
//   i_use_a_D/_b_D      D reads source A / source B
//   i_reg_*_select_D    source A, source B and destination register numbers
//   o_nop               stall D and push a bubble (combinational)
//   o_fwd_a/_b          0 = register file, k = forward from slot k-1
//   o_stall_cnt         saturating stall-cycle counter
// -----------------------------------------------------------------------------
module haz_scoreboard #(
    parameter int REG_SELECT  = 5,
    parameter int DEPTH       = 3,
    parameter int ALU_LAT     = 1,
    parameter int LOAD_LAT    = 2,
    parameter int CMP_DIST    = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_freeze,
    input  logic                           i_flush,
    input  logic                           i_valid_D,
    input  logic                           i_is_cmp_D,
    input  logic                           i_is_load_D,
    input  logic                           i_is_write_D,
    input  logic                           i_use_a_D,
    input  logic                           i_use_b_D,
    input  logic [REG_SELECT-1:0]          i_reg_a_select_D,
    input  logic [REG_SELECT-1:0]          i_reg_b_select_D,
    input  logic [REG_SELECT-1:0]          i_reg_c_select_D,
    output logic                           o_nop,
    output logic [$clog2(DEPTH+1)-1:0]     o_fwd_a,
    output logic [$clog2(DEPTH+1)-1:0]     o_fwd_b,
    output logic [STALL_CNT_W-1:0]         o_stall_cnt
);

    // A countdown never exceeds LOAD_LAT-1; keep at least one bit so the
    // entry stays well-formed when LOAD_LAT is 1.
    localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam int FWD_W = $clog2(DEPTH + 1);

    // Elaboration-time parameter legality checks
    generate
        if (ALU_LAT < 1) begin : g_err_alu_lat
            $error("haz_scoreboard: ALU_LAT must be at least 1");
        end
        if (LOAD_LAT < ALU_LAT) begin : g_err_load_lt_alu
            $error("haz_scoreboard: LOAD_LAT must not be below ALU_LAT");
        end
        if (LOAD_LAT > DEPTH) begin : g_err_load_gt_depth
            $error("haz_scoreboard: LOAD_LAT must not exceed DEPTH");
        end
        if (CMP_DIST > DEPTH) begin : g_err_cmp_dist
            $error("haz_scoreboard: CMP_DIST must not exceed DEPTH");
        end
    endgenerate

    // Scoreboard state: slot 0 is the stage right after D.
    logic [DEPTH-1:0]                 r_vld;
    logic [DEPTH-1:0][REG_SELECT-1:0] r_rd;
    logic [DEPTH-1:0][CNT_W-1:0]      r_cnt;
    logic [STALL_CNT_W-1:0]           r_stall_cnt;

    logic             w_hit_a;
    logic             w_hit_b;
    logic [FWD_W-1:0] w_code_a;
    logic [FWD_W-1:0] w_code_b;
    logic [CNT_W-1:0] w_cnt_a;
    logic [CNT_W-1:0] w_cnt_b;
    logic             w_early_a;
    logic             w_early_b;
    logic             w_haz_a;
    logic             w_haz_b;
    logic             w_nop;
    logic             w_push_vld;
    logic [CNT_W-1:0] w_push_cnt;

    // Countdown step as an entry moves one slot: decrement, floor at zero.
    function automatic logic [CNT_W-1:0] dec_floor(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt != {CNT_W{1'b0}}) begin
            res = cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            res = {CNT_W{1'b0}};
        end
        return res;
    endfunction

    // Youngest-match search per source. Scanning from the oldest slot down
    // lets a younger write overwrite (shadow) an older one to the same register.
    always_comb begin
        w_hit_a   = 1'b0;
        w_hit_b   = 1'b0;
        w_code_a  = {FWD_W{1'b0}};
        w_code_b  = {FWD_W{1'b0}};
        w_cnt_a   = {CNT_W{1'b0}};
        w_cnt_b   = {CNT_W{1'b0}};
        w_early_a = 1'b0;
        w_early_b = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_vld[i] && (r_rd[i] == i_reg_a_select_D)) begin
                w_hit_a   = 1'b1;
                w_code_a  = FWD_W'(i + 1);
                w_cnt_a   = r_cnt[i];
                w_early_a = (i < CMP_DIST);
            end else begin
                w_hit_a   = w_hit_a;
            end
            if (r_vld[i] && (r_rd[i] == i_reg_b_select_D)) begin
                w_hit_b   = 1'b1;
                w_code_b  = FWD_W'(i + 1);
                w_cnt_b   = r_cnt[i];
                w_early_b = (i < CMP_DIST);
            end else begin
                w_hit_b   = w_hit_b;
            end
        end
    end

    // Hazard, bubble, forward select and push-entry decode
    always_comb begin
        // Register 0 is hard-wired and an unused source never needs a value.
        w_haz_a = i_use_a_D && (i_reg_a_select_D != {REG_SELECT{1'b0}}) && w_hit_a &&
                  ((w_cnt_a != {CNT_W{1'b0}}) || (i_is_cmp_D && w_early_a));
        w_haz_b = i_use_b_D && (i_reg_b_select_D != {REG_SELECT{1'b0}}) && w_hit_b &&
                  ((w_cnt_b != {CNT_W{1'b0}}) || (i_is_cmp_D && w_early_b));

        // A flushed instruction is dropped anyway, so it never stalls.
        w_nop = i_valid_D && !i_flush && (w_haz_a || w_haz_b);

        if (i_use_a_D && (i_reg_a_select_D != {REG_SELECT{1'b0}}) && w_hit_a && !w_haz_a) begin
            o_fwd_a = w_code_a;
        end else begin
            o_fwd_a = {FWD_W{1'b0}};
        end
        if (i_use_b_D && (i_reg_b_select_D != {REG_SELECT{1'b0}}) && w_hit_b && !w_haz_b) begin
            o_fwd_b = w_code_b;
        end else begin
            o_fwd_b = {FWD_W{1'b0}};
        end

        w_push_vld = i_valid_D && i_is_write_D &&
                     (i_reg_c_select_D != {REG_SELECT{1'b0}}) && !w_nop && !i_flush;
        if (i_is_load_D) begin
            w_push_cnt = CNT_W'(LOAD_LAT - 1);
        end else begin
            w_push_cnt = CNT_W'(ALU_LAT - 1);
        end
    end

    // Scoreboard shift and stall counter; everything holds while frozen.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld       <= {DEPTH{1'b0}};
            r_stall_cnt <= {STALL_CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]  <= {REG_SELECT{1'b0}};
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else if (!i_freeze) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                r_vld[i] <= r_vld[i-1];
                r_rd[i]  <= r_rd[i-1];
                r_cnt[i] <= dec_floor(r_cnt[i-1]);
            end
            r_vld[0] <= w_push_vld;
            r_rd[0]  <= i_reg_c_select_D;
            r_cnt[0] <= w_push_cnt;
            if (w_nop && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end else begin
            r_vld       <= r_vld;
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign o_nop       = w_nop;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_haz_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_haz_scoreboard
//   Drives D-stage instruction sequences into two instances of haz_scoreboard
//   (default parameters, and a 2-bit stall counter). For every driven cycle the
//   expected outputs are pushed to a queue; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_haz_scoreboard;

    logic       clk;
    logic       rst;
    logic       freeze;
    logic       flush;
    logic       valid;
    logic       is_cmp;
    logic       is_load;
    logic       is_write;
    logic       use_a;
    logic       use_b;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [4:0] rc;

    logic        nop;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cnt;

    logic        sat_nop;
    logic [1:0]  sat_fwd_a;
    logic [1:0]  sat_fwd_b;
    logic [1:0]  sat_cnt;

    typedef struct {
        string       tag;
        logic        nop;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
        bit          chk_sat;
        logic [1:0]  sat;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    haz_scoreboard dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_freeze         (freeze),
        .i_flush          (flush),
        .i_valid_D        (valid),
        .i_is_cmp_D       (is_cmp),
        .i_is_load_D      (is_load),
        .i_is_write_D     (is_write),
        .i_use_a_D        (use_a),
        .i_use_b_D        (use_b),
        .i_reg_a_select_D (ra),
        .i_reg_b_select_D (rb),
        .i_reg_c_select_D (rc),
        .o_nop            (nop),
        .o_fwd_a          (fwd_a),
        .o_fwd_b          (fwd_b),
        .o_stall_cnt      (stall_cnt)
    );

    haz_scoreboard #(.STALL_CNT_W(2)) dut_sat (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_freeze         (freeze),
        .i_flush          (flush),
        .i_valid_D        (valid),
        .i_is_cmp_D       (is_cmp),
        .i_is_load_D      (is_load),
        .i_is_write_D     (is_write),
        .i_use_a_D        (use_a),
        .i_use_b_D        (use_b),
        .i_reg_a_select_D (ra),
        .i_reg_b_select_D (rb),
        .i_reg_c_select_D (rc),
        .o_nop            (sat_nop),
        .o_fwd_a          (sat_fwd_a),
        .o_fwd_b          (sat_fwd_b),
        .o_stall_cnt      (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: compare the outputs of each driven cycle against its expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_val({e.tag, ".nop"},   32'(nop),       32'(e.nop));
            check_val({e.tag, ".fwd_a"}, 32'(fwd_a),     32'(e.fa));
            check_val({e.tag, ".fwd_b"}, 32'(fwd_b),     32'(e.fb));
            check_val({e.tag, ".cnt"},   32'(stall_cnt), 32'(e.cnt));
            if (e.chk_sat) begin
                check_val({e.tag, ".sat"}, 32'(sat_cnt), 32'(e.sat));
            end
        end
    end

    task automatic idle();
        rst = 1'b0; freeze = 1'b0; flush = 1'b0;
        valid = 1'b0; is_cmp = 1'b0; is_load = 1'b0; is_write = 1'b0;
        use_a = 1'b0; use_b = 1'b0; ra = 5'd0; rb = 5'd0; rc = 5'd0;
    endtask

    task automatic d(input logic v, input logic cmp, input logic ld, input logic wr,
                     input logic ua, input logic ub,
                     input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        valid = v; is_cmp = cmp; is_load = ld; is_write = wr;
        use_a = ua; use_b = ub; ra = a; rb = b; rc = c;
    endtask

    // Queue the expectation for the current cycle, then move to the next drive point.
    task automatic expect_cyc(input string tag, input logic n, input logic [1:0] fa,
                              input logic [1:0] fb, input logic [15:0] cnt,
                              input bit chk_sat, input logic [1:0] sat);
        exp_t e;
        e.tag = tag; e.nop = n; e.fa = fa; e.fb = fb; e.cnt = cnt;
        e.chk_sat = chk_sat; e.sat = sat;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        idle();
        expect_cyc("reset", 1'b0, 2'd0, 2'd0, 16'd0, 1'b1, 2'd0);

        // ALU write r5, then add r5,r6 forwards from slot 0
        idle(); d(1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd5);
        expect_cyc("alu_w5", 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(); d(1, 0, 0, 1, 1, 1, 5'd5, 5'd6, 5'd7);
        expect_cyc("alu_fwd", 1'b0, 2'd1, 2'd0, 16'd0, 1'b0, 2'd0);

        // ALU write r5, compare r5 stalls once, then forwards from slot 1
        do_reset();
        idle(); d(1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd5);
        expect_cyc("cmp_w5", 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(); d(1, 1, 0, 0, 1, 0, 5'd5, 5'd0, 5'd0);
        expect_cyc("cmp_stall", 1'b1, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(); d(1, 1, 0, 0, 1, 0, 5'd5, 5'd0, 5'd0);
        expect_cyc("cmp_go", 1'b0, 2'd2, 2'd0, 16'd1, 1'b0, 2'd0);

        // Load r10, then add r7,r10: one stall then forward from slot 1
        do_reset();
        idle(); d(1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd10);
        expect_cyc("lu_load", 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(); d(1, 0, 0, 1, 1, 1, 5'd7, 5'd10, 5'd11);
        expect_cyc("lu_stall", 1'b1, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(); d(1, 0, 0, 1, 1, 1, 5'd7, 5'd10, 5'd11);
        expect_cyc("lu_go", 1'b0, 2'd0, 2'd2, 16'd1, 1'b0, 2'd0);
        idle();
        expect_cyc("lu_after", 1'b0, 2'd0, 2'd0, 16'd1, 1'b0, 2'd0);

        // Load r10, dependent D under freeze for 4 cycles: nothing moves
        do_reset();
        idle(); d(1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd10);
        expect_cyc("fz_load", 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            idle(); d(1, 0, 0, 0, 0, 1, 5'd0, 5'd10, 5'd0); freeze = 1'b1;
            expect_cyc("fz_hold", 1'b1, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        end
        idle(); d(1, 0, 0, 0, 0, 1, 5'd0, 5'd10, 5'd0);
        expect_cyc("fz_rel", 1'b1, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(); d(1, 0, 0, 0, 0, 1, 5'd0, 5'd10, 5'd0);
        expect_cyc("fz_go", 1'b0, 2'd0, 2'd2, 16'd1, 1'b0, 2'd0);

        // Two writes of r3: youngest shadows older; r0 and unused sources never stall
        do_reset();
        idle(); d(1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd3);
        expect_cyc("sh_w3a", 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(); d(1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd3);
        expect_cyc("sh_w3b", 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(); d(1, 0, 0, 0, 1, 0, 5'd3, 5'd0, 5'd0);
        expect_cyc("sh_use", 1'b0, 2'd1, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(); d(1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        expect_cyc("r0_load", 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(); d(1, 1, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0);
        expect_cyc("r0_use", 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(); d(1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd9);
        expect_cyc("un_load", 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(); d(1, 0, 0, 0, 0, 0, 5'd9, 5'd9, 5'd0);
        expect_cyc("un_nouse", 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);

        // Load-use with flush: no stall, and the flushed write leaves a bubble
        do_reset();
        idle(); d(1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd10);
        expect_cyc("fl_load", 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(); d(1, 0, 0, 1, 0, 1, 5'd0, 5'd10, 5'd12); flush = 1'b1;
        expect_cyc("fl_kill", 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(); d(1, 0, 0, 0, 1, 1, 5'd10, 5'd12, 5'd0);
        expect_cyc("fl_after", 1'b0, 2'd2, 2'd0, 16'd0, 1'b0, 2'd0);

        // Reset during a stall discards the in-flight load
        do_reset();
        idle(); d(1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd10);
        expect_cyc("rs_load", 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(); d(1, 0, 0, 0, 0, 1, 5'd0, 5'd10, 5'd0); rst = 1'b1;
        expect_cyc("rs_stall", 1'b1, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);
        idle(); d(1, 0, 0, 0, 0, 1, 5'd0, 5'd10, 5'd0);
        expect_cyc("rs_after", 1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 2'd0);

        // Saturation: chained loads of r10 reading r10 alternate stall / go
        do_reset();
        idle(); d(1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd10);
        expect_cyc("sat_first", 1'b0, 2'd0, 2'd0, 16'd0, 1'b1, 2'd0);
        for (int k = 0; k < 5; k++) begin
            idle(); d(1, 0, 1, 1, 1, 0, 5'd10, 5'd0, 5'd10);
            expect_cyc("sat_stall", 1'b1, 2'd0, 2'd0, 16'(k), 1'b1, (k > 3) ? 2'd3 : 2'(k));
            idle(); d(1, 0, 1, 1, 1, 0, 5'd10, 5'd0, 5'd10);
            expect_cyc("sat_go", 1'b0, 2'd2, 2'd0, 16'(k + 1), 1'b1, (k + 1 > 3) ? 2'd3 : 2'(k + 1));
        end
        idle();
        expect_cyc("sat_end", 1'b0, 2'd0, 2'd0, 16'd5, 1'b1, 2'd3);

        @(negedge clk);
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
